// File: rtl/cic_pkg.sv
// ============================================================================
// Module   : cic_pkg
// Brief    : Shared constants, state type and index-width helper for the CIC comb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cic_pkg;

    localparam int CIC_WIDTH    = 32;
    localparam int CIC_N_STAGES = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } comb_state_t;

    // A single-stage comb still needs a 1-bit index.
    function automatic int cic_idx_width(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/comb_delay_bank.sv
// ============================================================================
// Module   : comb_delay_bank
// Brief    : N_STAGES x WIDTH delay-line register file, one write and one read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comb_delay_bank #(
    parameter int WIDTH    = 32,
    parameter int N_STAGES = 4,
    parameter int IDX_W    = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [N_STAGES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_STAGES; i++) r_mem[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < N_STAGES; i++) r_mem[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_STAGES; i++) begin
                if (wr_idx == IDX_W'(i)) r_mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = r_mem[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/cic_comb_serial.sv
// ============================================================================
// Module   : cic_comb_serial
// Brief    : Serial CIC comb chain, one shared subtractor, one stage per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_comb_serial
    import cic_pkg::*;
#(
    parameter int WIDTH     = CIC_WIDTH,
    parameter int N_STAGES  = CIC_N_STAGES,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 strobe_in,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 strobe_out,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 busy,
    output logic                 overrun
);

    localparam int              c_idx_w = cic_idx_width(N_STAGES);
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(N_STAGES - 1);

    comb_state_t          r_state;
    logic [c_idx_w-1:0]   r_k;
    logic [WIDTH-1:0]     r_x;
    logic [OUT_WIDTH-1:0] r_data_out;
    logic                 r_strobe_out;
    logic [WIDTH-1:0]     w_dly;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_run;

    assign w_run  = (r_state == RUN);
    assign w_diff = r_x - w_dly;

    // Stage k's current input becomes its history for the next sample.
    comb_delay_bank #(
        .WIDTH    (WIDTH),
        .N_STAGES (N_STAGES),
        .IDX_W    (c_idx_w)
    ) u_dly (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!enable),
        .wr_en   (enable && w_run),
        .wr_idx  (r_k),
        .wr_data (r_x),
        .rd_idx  (r_k),
        .rd_data (w_dly)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_x          <= '0;
            r_data_out   <= '0;
            r_strobe_out <= 1'b0;
        end else begin
            r_strobe_out <= 1'b0;
            if (!enable) begin
                r_state <= IDLE;
                r_k     <= '0;
                r_x     <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (strobe_in) begin
                            r_x     <= data_in;
                            r_k     <= '0;
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        r_x <= w_diff;
                        if (r_k == c_last) begin
                            r_data_out   <= w_diff[WIDTH-1 -: OUT_WIDTH];
                            r_strobe_out <= 1'b1;
                            r_k          <= '0;
                            r_state      <= IDLE;
                        end else begin
                            r_k <= r_k + c_idx_w'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign strobe_out = r_strobe_out;
    assign data_out   = r_data_out;
    assign busy       = w_run;
    assign overrun    = enable && strobe_in && w_run;

endmodule

`default_nettype wire

// File: tb/tb_cic_comb_serial.sv
// ============================================================================
// Module   : tb_cic_comb_serial
// Brief    : Self-checking bench for cic_comb_serial against a binomial comb model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cic_comb_serial;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        strobe4 = 1'b0;
    logic        strobe1 = 1'b0;
    logic [31:0] data_in = '0;

    logic        so4, busy4, ovr4;
    logic [31:0] do4;
    logic        so1, busy1, ovr1;
    logic [31:0] do1;

    int checks = 0;
    int errors = 0;

    logic [31:0] hist4 [$];
    logic [31:0] hist1 [$];

    always #5 clock = ~clock;

    cic_comb_serial #(.WIDTH(32), .N_STAGES(4), .OUT_WIDTH(32)) dut4 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .strobe_in(strobe4),
        .data_in(data_in), .strobe_out(so4), .data_out(do4), .busy(busy4), .overrun(ovr4)
    );

    cic_comb_serial #(.WIDTH(32), .N_STAGES(1), .OUT_WIDTH(32)) dut1 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .strobe_in(strobe1),
        .data_in(data_in), .strobe_out(so1), .data_out(do1), .busy(busy1), .overrun(ovr1)
    );

    // N cascaded first differences = sum_j (-1)^j C(N,j) x[n-j], zero history before flush.
    function automatic logic [31:0] ref_out(input int n, input logic [31:0] h [$]);
        logic [31:0] acc;
        logic [31:0] term;
        int          c;
        acc = '0;
        c   = 1;
        for (int j = 0; j <= n; j++) begin
            term = (j < h.size()) ? h[h.size() - 1 - j] : 32'd0;
            if (j % 2 == 1) acc = acc - 32'(c) * term;
            else            acc = acc + 32'(c) * term;
            c = c * (n - j) / (j + 1);
        end
        return acc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one sample (after gap idle cycles) and check its result and latency.
    task automatic send(input int which, input logic [31:0] d, input int gap, input string tag);
        logic [31:0] exp;
        logic [31:0] got;
        int          ns;
        int          lat;
        ns = (which == 1) ? 1 : 4;
        repeat (gap) @(negedge clock);
        data_in = d;
        if (which == 1) begin
            strobe1 = 1'b1;
            hist1.push_back(d);
            exp = ref_out(1, hist1);
        end else begin
            strobe4 = 1'b1;
            hist4.push_back(d);
            exp = ref_out(4, hist4);
        end
        lat = -1;
        for (int c = 1; c <= ns + 4; c++) begin
            @(negedge clock);
            strobe1 = 1'b0;
            strobe4 = 1'b0;
            #1;
            if ((which == 1) ? so1 : so4) begin
                lat = c;
                break;
            end
        end
        got = (which == 1) ? do1 : do4;
        check({tag, "_latency"}, 32'(lat), 32'(ns + 1));
        check({tag, "_data"}, got, exp);
    endtask

    task automatic flush();
        @(negedge clock);
        enable = 1'b0;
        hist4.delete();
        hist1.delete();
        @(negedge clock);
        enable = 1'b1;
    endtask

    initial begin
        logic [31:0] held;
        int          seen;

        // Reset state
        #2;
        check("rst_data_out", do4, 32'd0);
        check("rst_strobe_out", {31'd0, so4}, 32'd0);
        check("rst_busy", {31'd0, busy4}, 32'd0);
        check("rst_overrun", {31'd0, ovr4}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Impulse
        send(4, 32'd1, 0, "imp0");
        for (int i = 0; i < 5; i++) send(4, 32'd0, 0, "imp");

        // Step from zero history
        flush();
        for (int i = 0; i < 6; i++) send(4, 32'd5, 0, "step");

        // Random samples, random spacing including back-to-back
        for (int i = 0; i < 24; i++) send(4, $urandom, $urandom_range(0, 3), "rand");

        // Overrun: second strobe two cycles later is dropped
        @(negedge clock);
        data_in = $urandom;
        strobe4 = 1'b1;
        hist4.push_back(data_in);
        @(negedge clock);
        strobe4 = 1'b0;
        #1;
        check("ovr_busy_t1", {31'd0, busy4}, 32'd1);
        check("ovr_none_t1", {31'd0, ovr4}, 32'd0);
        @(negedge clock);
        data_in = $urandom;
        strobe4 = 1'b1;
        #1;
        check("ovr_pulse_t2", {31'd0, ovr4}, 32'd1);
        @(negedge clock);
        strobe4 = 1'b0;
        #1;
        check("ovr_none_t3", {31'd0, ovr4}, 32'd0);
        check("ovr_busy_t3", {31'd0, busy4}, 32'd1);
        @(negedge clock);
        #1;
        check("ovr_busy_t4", {31'd0, busy4}, 32'd1);
        check("ovr_noout_t4", {31'd0, so4}, 32'd0);
        @(negedge clock);
        #1;
        check("ovr_out_t5", {31'd0, so4}, 32'd1);
        check("ovr_data_t5", do4, ref_out(4, hist4));
        check("ovr_busy_t5", {31'd0, busy4}, 32'd0);
        send(4, $urandom, 0, "ovr_third");

        // Abort: enable drops mid-run
        flush();
        @(negedge clock);
        held = do4;
        data_in = 32'd1234;
        strobe4 = 1'b1;
        @(negedge clock);
        strobe4 = 1'b0;
        @(negedge clock);
        enable = 1'b0;
        hist4.delete();
        hist1.delete();
        @(negedge clock);
        strobe4 = 1'b1;
        #1;
        check("abort_no_overrun", {31'd0, ovr4}, 32'd0);
        @(negedge clock);
        strobe4 = 1'b0;
        enable = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            #1;
            if (so4) seen++;
        end
        check("abort_no_strobe", 32'(seen), 32'd0);
        check("abort_busy", {31'd0, busy4}, 32'd0);
        check("abort_data_held", do4, held);
        send(4, 32'd7, 0, "abort_next");
        check("abort_next_value", do4, 32'd7);

        // Modulo wrap-around, single stage
        flush();
        send(1, 32'h7FFF_FFFF, 0, "wrap0");
        check("wrap0_value", do1, 32'h7FFF_FFFF);
        send(1, 32'h8000_0001, 1, "wrap1");
        check("wrap1_value", do1, 32'h0000_0002);

        // Asynchronous reset in the middle of a run
        @(negedge clock);
        data_in = 32'd99;
        strobe4 = 1'b1;
        @(negedge clock);
        strobe4 = 1'b0;
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy4}, 32'd0);
        check("arst_data_out", do4, 32'd0);
        check("arst_strobe_out", {31'd0, so4}, 32'd0);
        check("arst_dut1_data_out", do1, 32'd0);
        #1;
        reset_n = 1'b1;
        hist4.delete();
        hist1.delete();
        @(negedge clock);
        send(4, 32'd1, 0, "arst_imp0");
        for (int i = 0; i < 4; i++) send(4, 32'd0, 0, "arst_imp");
        check("arst_imp_last", do4, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
